// File: rtl/spi_frame_executor.sv
// Executes SPI slave frames as single req/ack bus transactions in the clk domain.
// Handles read/write decode, bus timeout, overrun detection and error reporting.
module spi_frame_executor #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter logic [7:0]  CMD_WR  = 8'hAA,
  parameter logic [7:0]  CMD_RD  = 8'h81,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_rdy,
  input  logic [7:0]        cmd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int unsigned     TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [1:0]      ERR_CMD  = 2'b01;
  localparam logic [1:0]      ERR_TMO  = 2'b10;
  localparam logic [1:0]      ERR_OVR  = 2'b11;

  typedef enum logic [1:0] {IDLE, DECODE, BUS, ERR} state_t;

  state_t            state, state_d;
  logic              s1, s2, s3;
  logic [2:0]        warm;
  logic              fev;
  logic [7:0]        c_cmd, c_cmd_d;
  logic [ADDR_W-1:0] c_addr, c_addr_d;
  logic [DATA_W-1:0] c_data, c_data_d;
  logic [TMO_W-1:0]  tmo, tmo_d;
  logic              bus_req_d, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_d;
  logic [DATA_W-1:0] rd_data_d;
  logic              rd_valid_d, busy_d, err_d;
  logic [1:0]        err_code_d;

  // warm masks the first three edges after reset, so a frame_rdy already
  // high at release (a frame from before reset) never produces an event
  assign fev = s2 & ~s3 & warm[2];

  // frame_rdy synchroniser and power-on qualifier
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      warm <= 3'b000;
    end else begin
      s1   <= frame_rdy;
      s2   <= s1;
      s3   <= s2;
      warm <= {warm[1:0], 1'b1};
    end
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      c_cmd     <= '0;
      c_addr    <= '0;
      c_data    <= '0;
      tmo       <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      state     <= state_d;
      c_cmd     <= c_cmd_d;
      c_addr    <= c_addr_d;
      c_data    <= c_data_d;
      tmo       <= tmo_d;
      bus_req   <= bus_req_d;
      bus_we    <= bus_we_d;
      bus_addr  <= bus_addr_d;
      bus_wdata <= bus_wdata_d;
      rd_data   <= rd_data_d;
      rd_valid  <= rd_valid_d;
      busy      <= busy_d;
      err       <= err_d;
      err_code  <= err_code_d;
    end
  end

  // next-state and next-output logic
  always_comb begin
    state_d     = state;
    c_cmd_d     = c_cmd;
    c_addr_d    = c_addr;
    c_data_d    = c_data;
    tmo_d       = tmo;
    bus_req_d   = bus_req;
    bus_we_d    = bus_we;
    bus_addr_d  = bus_addr;
    bus_wdata_d = bus_wdata;
    rd_data_d   = rd_data;
    rd_valid_d  = 1'b0;
    err_d       = 1'b0;
    err_code_d  = err_code;

    case (state)
      IDLE: begin
        if (fev) begin
          c_cmd_d  = cmd;
          c_addr_d = addr;
          c_data_d = data_in;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        if (c_cmd == CMD_WR || c_cmd == CMD_RD) begin
          state_d     = BUS;
          bus_req_d   = 1'b1;
          bus_we_d    = (c_cmd == CMD_WR);
          bus_addr_d  = c_addr;
          bus_wdata_d = (c_cmd == CMD_WR) ? c_data : '0;
          tmo_d       = '0;
        end else begin
          state_d    = ERR;
          err_d      = 1'b1;
          err_code_d = ERR_CMD;
        end
      end
      BUS: begin
        if (bus_ack) begin
          bus_req_d = 1'b0;
          state_d   = IDLE;
          if (!bus_we) begin
            rd_data_d  = bus_rdata;
            rd_valid_d = 1'b1;
          end
        end else if (tmo == TMO_LAST) begin
          bus_req_d  = 1'b0;
          state_d    = ERR;
          err_d      = 1'b1;
          err_code_d = ERR_TMO;
        end else begin
          tmo_d = tmo + TMO_W'(1);
        end
      end
      ERR: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // overrun: frame dropped; ERR already carries a pulse this cycle
    if (fev && state != IDLE) begin
      err_code_d = ERR_OVR;
      if (state != ERR) err_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_spi_frame_executor.sv
// Randomised bench for spi_frame_executor: each frame is scored against a
// transaction-level model of the expected bus activity, errors and read data.
module tb_spi_frame_executor;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int          TO = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_rdy;
  logic [7:0]    cmd;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic          bus_req, bus_we, bus_ack;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata, bus_rdata, rd_data;
  logic          rd_valid, busy, err;
  logic [1:0]    err_code;

  spi_frame_executor #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .frame_rdy(frame_rdy), .cmd(cmd), .addr(addr),
    .data_in(data_in), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .err(err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // bus-side monitor, sampled on the falling edge
  int            req_cycles, req_starts, err_cycles, err_pulses, rv_cycles;
  bit            hold_bad, prev_req, prev_err;
  logic          cap_we;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_wdata;

  always @(negedge clk) begin
    if (bus_req) begin
      req_cycles++;
      if (!prev_req) begin
        req_starts++;
        cap_we = bus_we; cap_addr = bus_addr; cap_wdata = bus_wdata;
      end else if (bus_we !== cap_we || bus_addr !== cap_addr || bus_wdata !== cap_wdata) begin
        hold_bad = 1'b1;
      end
    end
    if (err && !prev_err) err_pulses++;
    err_cycles += int'(err);
    rv_cycles  += int'(rd_valid);
    prev_req = bus_req;
    prev_err = err;
  end

  task automatic clear_mon();
    req_cycles = 0; req_starts = 0; err_cycles = 0; err_pulses = 0;
    rv_cycles = 0; hold_bad = 1'b0;
  endtask

  // reference state carried across frames
  logic [1:0]    m_code = 2'b00;
  logic [DW-1:0] m_rd   = '0;

  // one frame; ack_k = falling edges after req first seen before ack is driven
  task automatic run_txn(input logic [7:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int ack_k, input logic [DW-1:0] rdata, input bit ovr);
    bit good, is_rd, acked;
    int exp_len, lat;
    good  = (c == 8'hAA) || (c == 8'h81);
    is_rd = (c == 8'h81);
    acked = good && ack_k < TO;
    exp_len = acked ? ack_k + 1 : TO;
    @(negedge clk);
    clear_mon();
    cmd = c; addr = a; data_in = d; frame_rdy = 1'b1;
    if (good) begin
      lat = 0;
      while (!bus_req && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      chk("req_latency", 64'(lat), 64'd4);
      for (int i = 0; i < TO + 4; i++) begin
        if (i > 0) @(negedge clk);
        bus_ack   = (i == ack_k);
        bus_rdata = (i == ack_k) ? rdata : DW'($urandom);
        if (ovr && i == 0) frame_rdy = 1'b0;
        if (ovr && i == 1) begin
          frame_rdy = 1'b1; cmd = 8'($urandom); addr = AW'($urandom); data_in = DW'($urandom);
        end
      end
      @(negedge clk);
      bus_ack = 1'b0;
    end else begin
      repeat (8) @(negedge clk);
    end
    frame_rdy = 1'b0;
    repeat (4) @(negedge clk);

    if (ovr) m_code = 2'b11;
    else if (!good) m_code = 2'b01;
    else if (!acked) m_code = 2'b10;
    if (is_rd && acked) m_rd = rdata;

    chk("req_count", 64'(req_starts), good ? 64'd1 : 64'd0);
    if (good) begin
      chk("req_len", 64'(req_cycles), 64'(exp_len));
      chk("req_we", 64'(cap_we), is_rd ? 64'd0 : 64'd1);
      chk("req_addr", 64'(cap_addr), 64'(a));
      chk("req_wdata", 64'(cap_wdata), is_rd ? 64'd0 : 64'(d));
      chk("req_hold", 64'(hold_bad), 64'd0);
    end
    chk("err_pulses", 64'(err_pulses), (!acked || ovr) ? 64'd1 : 64'd0);
    chk("err_cycles", 64'(err_cycles), (!acked || ovr) ? 64'd1 : 64'd0);
    chk("err_code", 64'(err_code), 64'(m_code));
    chk("rd_valid_cycles", 64'(rv_cycles), (is_rd && acked) ? 64'd1 : 64'd0);
    chk("rd_data", 64'(rd_data), 64'(m_rd));
    chk("busy_end", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int k;
    bit ov;
    logic [7:0] c;
    reset = 1'b0; frame_rdy = 1'b0; cmd = '0; addr = '0; data_in = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    clear_mon();
    repeat (3) @(negedge clk);
    chk("rst_bus_req", 64'(bus_req), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_err_code", 64'(err_code), 64'd0);
    chk("rst_rd", 64'({rd_valid, rd_data}), 64'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    run_txn(8'hAA, 16'h1234, 32'hDEADBEEF, 3, 32'h0, 1'b0);
    run_txn(8'h81, 16'h0010, 32'h11111111, 1, 32'hCAFEF00D, 1'b0);
    run_txn(8'h55, 16'h0001, 32'h0, 0, 32'h0, 1'b0);
    run_txn(8'hAA, 16'h4321, 32'h0BADF00D, 99, 32'h0, 1'b0);
    run_txn(8'hAA, 16'h0BEE, 32'h12345678, 6, 32'h0, 1'b1);
    run_txn(8'h81, 16'h2222, 32'h0, 0, 32'h600DD00D, 1'b0);
    run_txn(8'h81, 16'h3333, 32'h0, TO - 1, 32'hA5A5A5A5, 1'b1);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0, 1: c = 8'hAA;
        2:    c = 8'h81;
        default: begin
          c = 8'($urandom);
          if (c == 8'hAA || c == 8'h81) c = 8'h00;
        end
      endcase
      k  = int'($urandom_range(0, TO + 2));
      ov = (c == 8'hAA || c == 8'h81) && k >= 3 && k <= TO - 1 && $urandom_range(0, 3) == 0;
      run_txn(c, AW'($urandom), DW'($urandom), k, DW'($urandom), ov);
    end

    // reset mid-transaction with frame_rdy left high
    @(negedge clk);
    clear_mon();
    cmd = 8'hAA; addr = 16'h7777; data_in = 32'h01020304; frame_rdy = 1'b1;
    k = 0;
    while (!bus_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("rst_mid_req_seen", 64'(bus_req), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_bus_req", 64'(bus_req), 64'd0);
    chk("rst_mid_err_code", 64'(err_code), 64'd0);
    m_code = 2'b00; m_rd = '0;
    @(negedge clk);
    reset = 1'b1;
    clear_mon();
    repeat (12) @(negedge clk);
    chk("held_rdy_no_req", 64'(req_starts), 64'd0);
    chk("held_rdy_busy", 64'(busy), 64'd0);
    frame_rdy = 1'b0;
    repeat (4) @(negedge clk);
    run_txn(8'h81, 16'h7777, 32'h0, 2, 32'h13579BDF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
